pipe_frontend_ctrl: RTL and testbench

- Hazard and sequencing controller for the pipeline front end: PC register, IF/ID register, ID/EX bubble insertion.
- Detects load-use hazards, applies taken-branch/jump flushes to IF/ID, and freezes the front end while instruction memory is not ready.
- Includes a watchdog that traps a hung fetch, and saturating stall/flush performance counters.
- Sits beside the IF/ID register; drives its write-enable and flush inputs and the PC write-enable.

---
 rtl/pipe_frontend_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_frontend_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_frontend_ctrl.sv
// rtl/pipe_frontend_ctrl.sv - front-end hazard/sequencing controller with fetch watchdog
module pipe_frontend_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             redirect,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  localparam logic [1:0] S_RUN       = 2'd0;
  localparam logic [1:0] S_IMEM_WAIT = 2'd1;
  localparam logic [1:0] S_FAULT     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic flush_apply;
  logic stall_inc;

  // r0 is hardwired zero, so a load into it can never create a dependency
  assign load_use = ex_mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

  always_comb begin
    imem_req    = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b1;
    idex_bubble = 1'b1;
    fault       = 1'b0;
    if (rst) begin
      imem_req = 1'b0;
    end else if (state_q == S_FAULT) begin
      fault = 1'b1;
    end else begin
      imem_req = 1'b1;
      // a frozen fetch holds any branch in ID, so redirect is re-presented later
      if (!imem_ready || load_use) begin
        ifid_flush = 1'b0;
      end else begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = redirect;
        idex_bubble = 1'b0;
      end
    end
  end

  assign flush_apply = ~rst & (state_q != S_FAULT) & imem_ready & ~load_use & redirect;
  assign stall_inc   = ~rst & (state_q != S_FAULT) & ~pc_write;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_RUN: begin
        if (!imem_ready) begin
          state_d    = S_IMEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      S_IMEM_WAIT: begin
        if (imem_ready) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d == TIMEOUT_V) state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_apply && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_frontend_ctrl.sv
// tb/tb_pipe_frontend_ctrl.sv - scoreboard bench for pipe_frontend_ctrl
module tb_pipe_frontend_ctrl;

  localparam int CW = 4;

  // {imem_req, pc_write, ifid_write, ifid_flush, idex_bubble, fault}
  localparam logic [5:0] O_RST   = 6'b000110;
  localparam logic [5:0] O_RUN   = 6'b111000;
  localparam logic [5:0] O_STALL = 6'b100010;
  localparam logic [5:0] O_FLUSH = 6'b111100;
  localparam logic [5:0] O_FLT   = 6'b000111;

  typedef struct packed {
    logic [15:0]   idx;
    logic [5:0]    outs;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic ex_mem_read, redirect, imem_ready;
  logic imem_req, pc_write, ifid_write, ifid_flush, idex_bubble, fault;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int vec_n  = 0;

  always #5 clk = ~clk;

  pipe_frontend_ctrl #(.TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .redirect(redirect),
    .imem_ready(imem_ready), .imem_req(imem_req), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fault(fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // monitor: outputs are combinational, so every cycle presents a response
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] got;
      e   = exp_q.pop_front();
      got = {imem_req, pc_write, ifid_write, ifid_flush, idex_bubble, fault};
      checks = checks + 1;
      if (got !== e.outs || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        errors = errors + 1;
        $display("FAIL vec%0d: outs=%b stall=%0d flush=%0d, expected outs=%b stall=%0d flush=%0d",
                 e.idx, got, stall_cnt, flush_cnt, e.outs, e.sc, e.fc);
      end
    end
  end

  task automatic step(input logic r, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic rd,
                      input logic rdy, input logic [5:0] eo,
                      input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    redirect = rd; imem_ready = rdy;
    e.idx  = 16'(vec_n);
    e.outs = eo;
    e.sc   = CW'(sc);
    e.fc   = CW'(fc);
    exp_q.push_back(e);
    vec_n = vec_n + 1;
  endtask

  initial begin
    rst = 1'b1; ex_mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
    redirect = 1'b0; imem_ready = 1'b1;
    @(posedge clk);

    // reset held three cycles, then RUN immediately
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, O_RST, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, O_RUN, 0, 0);

    // load-use on rs, then on rt; r0 and non-load never stall
    step(0, 1, 5, 5, 0, 0, 1, O_STALL, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, O_RUN,   1, 0);
    step(0, 1, 7, 0, 7, 0, 1, O_STALL, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, O_RUN,   2, 0);
    step(0, 1, 0, 0, 0, 0, 1, O_RUN,   2, 0);
    step(0, 0, 5, 5, 5, 0, 1, O_RUN,   2, 0);

    // redirect alone flushes; with load-use it only stalls
    step(0, 0, 0, 0, 0, 1, 1, O_FLUSH, 2, 0);
    step(0, 1, 3, 3, 0, 1, 1, O_STALL, 2, 1);
    step(0, 0, 0, 0, 0, 0, 1, O_RUN,   3, 1);

    // one-cycle reset clears counters
    step(1, 0, 0, 0, 0, 0, 1, O_RST, 3, 1);
    step(0, 0, 0, 0, 0, 0, 1, O_RUN, 0, 0);

    // memory wait with redirect pending: freeze, then flush on ready
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, O_STALL, i, 0);
    step(0, 0, 0, 0, 0, 1, 1, O_FLUSH, 3, 0);
    step(0, 0, 0, 0, 0, 0, 1, O_RUN,   3, 1);

    // watchdog: 4 not-ready cycles trap into FAULT, which ignores inputs
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, O_STALL, 3 + i, 1);
    step(0, 0, 0, 0, 0, 0, 0, O_FLT, 7, 1);
    step(0, 0, 0, 0, 0, 1, 1, O_FLT, 7, 1);
    step(0, 1, 4, 4, 0, 0, 1, O_FLT, 7, 1);
    step(1, 0, 0, 0, 0, 0, 1, O_RST, 7, 1);
    step(0, 0, 0, 0, 0, 0, 1, O_RUN, 0, 0);

    // reset mid-wait returns to RUN
    step(0, 0, 0, 0, 0, 0, 0, O_STALL, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, O_STALL, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, O_RST,   2, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, O_STALL, i, 0);
    step(0, 0, 0, 0, 0, 0, 1, O_RUN, 3, 0);

    // saturation of both counters
    step(1, 0, 0, 0, 0, 0, 1, O_RST, 3, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 9, 9, 0, 0, 1, O_STALL, (i > 15) ? 15 : i, 0);
    step(0, 0, 0, 0, 0, 0, 1, O_RUN, 15, 0);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 0, 1, 1, O_FLUSH, 15, (i > 15) ? 15 : i);
    step(0, 0, 0, 0, 0, 0, 1, O_RUN, 15, 15);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: pending=%0d, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
